// File: rtl/seq_detector_param.sv
// seq_detector_param: serial bit-pattern detector with a loadable pattern, overlap control and Mealy/Moore output.
// Optional saturating match counter when SEQ_DETECTOR_MATCH_COUNT_EN is defined.
`timescale 1ns/1ps
module seq_detector_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             pat_load,
    input  logic             overlap,
    input  logic             mealy,
    output logic             z
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             cnt_clr
`endif
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [15:0] PAT_RST_16 = 16'h0006;
    localparam logic [PAT_W-1:0] PAT_RST = PAT_RST_16[PAT_W-1:0];

    logic [PAT_W-2:0]  hist;
    logic [PAT_W-1:0]  pat_r;
    logic [FILL_W-1:0] fill;
    logic              z_q;
    logic [PAT_W-1:0]  window;
    logic              hit;

    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        return (f == FILL_MAX) ? f : f + 1'b1;
    endfunction

    // fill counts valid bits held in hist; a compare is only meaningful once it saturates.
    assign window = {hist, x};
    assign hit    = x_valid && (fill == FILL_MAX) && (window == pat_r);
    assign z      = mealy ? hit : z_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist  <= '0;
            fill  <= '0;
            z_q   <= 1'b0;
            pat_r <= PAT_RST;
        end else if (pat_load) begin
            // A new pattern restarts detection; a coincident hit is dropped.
            pat_r <= pat_in;
            fill  <= '0;
            z_q   <= 1'b0;
        end else begin
            z_q <= hit;
            if (x_valid) begin
                hist <= window[PAT_W-2:0];
                fill <= (hit && !overlap) ? '0 : fill_inc(fill);
            end
        end
    end

`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (hit && !pat_load) begin
            match_cnt <= cnt_inc(match_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=4, CNT_W=2); counter checks only when
// SEQ_DETECTOR_MATCH_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_seq_detector_param;

    logic       clk;
    logic       reset;
    logic       x;
    logic       x_valid;
    logic [3:0] pat_in;
    logic       pat_load;
    logic       overlap;
    logic       mealy;
    logic       z;
    logic [1:0] match_cnt;
    logic       cnt_clr;

    int total = 0;
    int bad   = 0;

    seq_detector_param #(
        .PAT_W(4),
        .CNT_W(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .x_valid  (x_valid),
        .pat_in   (pat_in),
        .pat_load (pat_load),
        .overlap  (overlap),
        .mealy    (mealy),
        .z        (z)
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        ,
        .match_cnt(match_cnt),
        .cnt_clr  (cnt_clr)
`endif
    );

`ifndef SEQ_DETECTOR_MATCH_COUNT_EN
    assign match_cnt = 2'b00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
        chk(tag, 32'(match_cnt), exp);
`else
        if (tag.len() < 0) $display("%0d", exp);
`endif
    endtask

    // Inputs change 1 ns after the rising edge; outputs are observed at the falling edge.
    task automatic drive(input logic b, input logic v, input logic ld, input logic clr);
        @(posedge clk);
        #1;
        x        = b;
        x_valid  = v;
        pat_load = ld;
        cnt_clr  = clr;
        @(negedge clk);
    endtask

    task automatic cyc(input logic b, input logic v);
        drive(b, v, 1'b0, 1'b0);
    endtask

    task automatic reload(input logic [3:0] p, input logic clr);
        pat_in = p;
        drive(1'b0, 1'b0, 1'b1, clr);
    endtask

    // Vectors are written in time order, first cycle in the leftmost of the n bits.
    task automatic run(input string tag, input int n, input logic [15:0] b,
                       input logic [15:0] v, input logic [15:0] ze);
        for (int i = 0; i < n; i++) begin
            cyc(b[n-1-i], v[n-1-i]);
            chk($sformatf("%s_z%0d", tag, i), 32'(z), 32'(ze[n-1-i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        x        = 1'b0;
        x_valid  = 1'b0;
        pat_in   = 4'b0000;
        pat_load = 1'b0;
        overlap  = 1'b0;
        mealy    = 1'b0;
        cnt_clr  = 1'b0;

        #2;
        chk("rst_z_moore", 32'(z), 0);
        mealy   = 1'b1;
        x       = 1'b0;
        x_valid = 1'b1;
        #4;
        chk("rst_z_mealy", 32'(z), 0);
        chk_cnt("rst_cnt", 0);
        x_valid = 1'b0;
        mealy   = 1'b0;
        #6;
        reset = 1'b1;

        // Overlapping detection against the reset pattern 0110
        overlap = 1'b1;
        run("ovl", 8, 16'b0000_0000_0110_1100, 16'b0000_0000_1111_1110, 16'b0000_0000_0000_1001);
        chk_cnt("ovl_cnt", 2);

        // Non-overlapping detection
        overlap = 1'b0;
        reload(4'b0110, 1'b1);
        run("novl", 8, 16'b0000_0000_0110_1100, 16'b0000_0000_1111_1110, 16'b0000_0000_0000_1000);
        chk_cnt("novl_cnt", 1);

        // Mealy vs Moore timing
        mealy = 1'b1;
        reload(4'b0110, 1'b1);
        run("mealy", 6, 16'b0000_0000_0001_1000, 16'b0000_0000_0011_1100, 16'b0000_0000_0000_0100);
        chk_cnt("mealy_cnt", 1);
        mealy = 1'b0;
        reload(4'b0110, 1'b1);
        run("moore", 6, 16'b0000_0000_0001_1000, 16'b0000_0000_0011_1100, 16'b0000_0000_0000_0010);
        chk_cnt("moore_cnt", 1);

        // Async reset between edges discards partial history
        reload(4'b0110, 1'b0);
        run("arst_pre", 3, 16'h0003, 16'h0007, 16'h0000);
        #1;
        reset = 1'b0;
        #0.5;
        chk("arst_z", 32'(z), 0);
        chk_cnt("arst_cnt", 0);
        #0.5;
        reset = 1'b1;
        run("arst_post", 7, 16'h0018, 16'h007C, 16'h0002);
        chk_cnt("arst_post_cnt", 1);

        // Valid gaps (gap cycles carry x=1 to show they are ignored)
        mealy = 1'b1;
        reload(4'b0110, 1'b1);
        run("gap", 8, 16'b0000_0000_0111_1101, 16'b0000_0000_1010_0110, 16'b0000_0000_0000_0010);
        chk_cnt("gap_cnt", 1);

        // Pattern load on the final-bit edge drops that hit
        mealy = 1'b0;
        reload(4'b0110, 1'b1);
        run("ld_pre", 3, 16'h0003, 16'h0007, 16'h0000);
        pat_in = 4'b1001;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        run("ld_post", 5, 16'h0012, 16'h001E, 16'h0001);
        chk_cnt("ld_cnt", 1);

        // Counter saturation with 5 overlapping matches, then clear against a hit
        overlap = 1'b1;
        reload(4'b0110, 1'b1);
        run("sat", 16, 16'b0110_1101_1011_0110, 16'hFFFF, 16'b0000_1001_0010_0100);
        cyc(1'b0, 1'b0);
        chk("sat_z_last", 32'(z), 1);
        chk_cnt("sat_cnt", 3);
        run("clr_pre", 2, 16'h0003, 16'h0003, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        chk_cnt("clr_before", 3);
        cyc(1'b0, 1'b0);
        chk("clr_z", 32'(z), 1);
        chk_cnt("clr_hit_cnt", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port x, input, 1 bit: serial data bit.
REQ-006 SHALL have port x_valid, input, 1 bit: x is sampled only on edges where x_valid=1.
REQ-007 SHALL have port pat_in, input, PAT_W bits: new pattern, MSB is the first bit received.
REQ-008 SHALL have port pat_load, input, 1 bit: loads pat_in into the internal pattern register.
REQ-009 SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port mealy, input, 1 bit: 1 = Mealy (combinational) z, 0 = Moore (registered) z.
REQ-011 SHALL have port z, output, 1 bit: match indication.
REQ-012 SHALL have port match_cnt, output, CNT_W bits: saturating match count (present only per REQ-030).
REQ-013 SHALL have port cnt_clr, input, 1 bit: synchronous counter clear (present only per REQ-030).

Function
REQ-014 SHALL keep hist (PAT_W-1 bits), pat_r (PAT_W bits), fill (0..PAT_W-1, saturating) and z_q (1 bit).
REQ-015 SHALL compute hit = x_valid & (fill==PAT_W-1) & ({hist,x}==pat_r), with x as the LSB.
REQ-016 SHALL, on each edge with x_valid=1, shift x into the LSB of hist and increment fill, saturating at PAT_W-1.
REQ-017 SHALL leave hist and fill unchanged on edges with x_valid=0; hit is 0 in those cycles.
REQ-018 SHALL, on an edge with hit=1 and overlap=0, set fill to 0, so the next match needs PAT_W fresh bits.
REQ-019 SHALL, on an edge with hit=1 and overlap=1, update fill per REQ-016, so matches may share bits.
REQ-020 SHALL drive z=hit combinationally when mealy=1, i.e. asserted in the same cycle as the final bit.
REQ-021 SHALL register z_q<=hit every edge and drive z=z_q when mealy=0: one cycle after the final bit, exactly one cycle wide per match.
REQ-022 SHALL, on an edge with pat_load=1, load pat_r<=pat_in, set fill to 0 and z_q to 0; this takes priority over a simultaneous hit (that hit is discarded and not counted).
REQ-023 SHALL allow mealy and overlap to change on any cycle; new values take effect on that cycle's hit and z without flushing history.
REQ-024 SHALL, when the counter is built in, increment match_cnt on every edge with hit=1 and pat_load=0, saturating at 2^CNT_W-1 with no wrap.
REQ-025 SHALL, on an edge with cnt_clr=1, set match_cnt to 0; clear wins over a simultaneous increment.

Reset
REQ-026 SHALL, while reset=0, immediately clear hist, fill, z_q and match_cnt to 0, independent of clk.
REQ-027 SHALL set pat_r to the reset value 4'b0110 zero-extended/truncated to PAT_W, LSB-aligned; z=0 during reset in both modes.
REQ-028 SHALL treat reset asserted mid-pattern as discarding all partial history: after release, PAT_W new valid bits are required before any match.
REQ-029 SHALL sample the first bit on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL gate the match counter on the macro SEQ_DETECTOR_MATCH_COUNT_EN: when defined, match_cnt and cnt_clr exist and behave per REQ-024/025; when undefined, both ports and the counter logic are absent and all other behaviour is unchanged.

Verification
REQ-031 SHALL cover overlap: PAT_W=4, pat 0110, overlap=1, mealy=0, stream 0,1,1,0,1,1,0 -> z pulses after bits 4 and 7, match_cnt=2.
REQ-032 SHALL cover non-overlap: same stream with overlap=0 -> single z pulse after bit 4, match_cnt=1.
REQ-033 SHALL cover Mealy/Moore timing: stream 0110 with mealy=1 -> z high during the 4th-bit cycle; with mealy=0 -> z high the following cycle only.
REQ-034 SHALL cover async reset mid-pattern: bits 0,1,1, async reset pulse 1 ns between edges, then 0 -> no match; then 0,1,1,0 -> match.
REQ-035 SHALL cover valid gaps and reload: x_valid=0 cycles inserted between 0110 bits -> match still detected; pat_load 1001 on the final-bit edge -> no match counted, next 1001 matches.
REQ-036 SHALL cover counter saturation: CNT_W=2, 5 overlapping matches -> match_cnt holds 3; cnt_clr together with a hit -> match_cnt=0.
